// File: rtl/md_ctrl_if.sv
// md_ctrl_if: E-stage to multiply/divide controller signal bundle.
interface md_ctrl_if;
    logic        op_valid;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        rd_sel;
    logic [31:0] rdata;
    logic        busy;
    logic        d_md;
    logic        stall;
    modport master (output op_valid, md_op, a, b, rd_sel, d_md, input rdata, busy, stall);
    modport slave  (input op_valid, md_op, a, b, rd_sel, d_md, output rdata, busy, stall);
endinterface

// File: rtl/md_ctrl.sv
// md_ctrl: fixed-latency mult/div sequencer owning HI/LO for the E stage.
// Optional macro MD_CANCEL_EN adds a cancel input that flushes a running op.
module md_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic       clk,
    input logic       reset_n,
`ifdef MD_CANCEL_EN
    input logic       cancel,
`endif
    md_ctrl_if.slave  m
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t      state, state_nx;
    logic [4:0]  cnt, cnt_nx;
    logic [31:0] hi, lo, pend_hi, pend_lo, res_hi, res_lo;
    logic [31:0] a_mag, b_mag, div_b, uq, ur, dq, dr;
    logic [63:0] prod_s, prod_u;
    logic        pend_wr, kill, sgn, idle, start, mt, commit;
`ifdef MD_CANCEL_EN
    assign kill = cancel;
`else
    assign kill = 1'b0;
`endif
    assign prod_s = {{32{m.a[31]}}, m.a} * {{32{m.b[31]}}, m.b};
    assign prod_u = {32'b0, m.a} * {32'b0, m.b};
    // Signed divide runs on magnitudes; 0x80000000 / -1 wraps back to 0x80000000
    assign sgn    = ~m.md_op[0];
    assign a_mag  = (sgn & m.a[31]) ? -m.a : m.a;
    assign b_mag  = (sgn & m.b[31]) ? -m.b : m.b;
    assign div_b  = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign uq     = a_mag / div_b;
    assign ur     = a_mag % div_b;
    assign dq     = (sgn & (m.a[31] ^ m.b[31])) ? -uq : uq;
    assign dr     = (sgn & m.a[31]) ? -ur : ur;
    assign res_hi = m.md_op[1] ? dr : (m.md_op[0] ? prod_u[63:32] : prod_s[63:32]);
    assign res_lo = m.md_op[1] ? dq : (m.md_op[0] ? prod_u[31:0] : prod_s[31:0]);
    assign idle   = state == IDLE;
    assign start  = m.op_valid & idle & ~m.md_op[2] & ~kill;
    assign mt     = m.op_valid & idle & (m.md_op[2:1] == 2'b10) & ~kill;
    assign commit = (state == RUN) & (cnt == 5'd1) & ~kill & pend_wr;
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (kill) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else if (start) begin
            state_nx = RUN;
            cnt_nx   = m.md_op[1] ? 5'(DIV_CYCLES) : 5'(MULT_CYCLES);
        end else if (state == RUN) begin
            cnt_nx   = cnt - 5'd1;
            state_nx = (cnt == 5'd1) ? IDLE : RUN;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (start) begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                pend_wr <= ~(m.md_op[1] & (m.b == 32'd0));
            end
            if (commit) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
            if (mt & ~m.md_op[0]) hi <= m.a;
            if (mt & m.md_op[0]) lo <= m.a;
        end
    end
    assign m.busy  = state == RUN;
    assign m.stall = m.d_md & (m.busy | (m.op_valid & ~m.md_op[2]));
    assign m.rdata = m.rd_sel ? hi : lo;
endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: directed vectors; a queue-based monitor checks busy length and HI/LO
// whenever busy falls or the stimulus requests a read-back.
module tb_md_ctrl;
    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
`ifdef MD_CANCEL_EN
    logic cancel = 1'b0;
`endif
    int errors = 0;
    int checks = 0;
    int req_cnt = 0;
    exp_t q[$];
    md_ctrl_if m();
    md_ctrl dut (
        .clk(clk),
        .reset_n(reset_n),
`ifdef MD_CANCEL_EN
        .cancel(cancel),
`endif
        .m(m)
    );
    always #5 clk = ~clk;
    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask
    // Monitor: sole driver of rd_sel
    initial begin
        int bcnt = 0;
        int seen = 0;
        logic was_busy = 1'b0;
        logic bz;
        exp_t e;
        m.rd_sel = 1'b0;
        forever begin
            @(negedge clk);
            bz = m.busy;
            if (bz === 1'b1) bcnt++;
            else if (was_busy || req_cnt != seen) begin
                seen = req_cnt;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: busy fell with no expected entry at %0t", $time);
                end else begin
                    e = q.pop_front();
                    check("busy_cycles", 32'(bcnt), 32'(e.cyc));
                    m.rd_sel = 1'b1;
                    #1 check("hi", m.rdata, e.hi);
                    m.rd_sel = 1'b0;
                    #1 check("lo", m.rdata, e.lo);
                end
                bcnt = 0;
            end
            was_busy = bz;
        end
    end
    task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
        @(posedge clk); #1;
        m.op_valid = 1'b1; m.md_op = op; m.a = av; m.b = bv;
        @(posedge clk); #1;
        m.op_valid = 1'b0;
    endtask
    task automatic wait_idle();
        int n = 0;
        while (m.busy !== 1'b0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: busy still %b after %0d cycles", m.busy, n);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask
    task automatic expect_op(input logic [31:0] h, input logic [31:0] l, input int c);
        q.push_back('{h, l, c});
    endtask
    task automatic req(input logic [31:0] h, input logic [31:0] l);
        q.push_back('{h, l, 0});
        req_cnt++;
        repeat (2) @(posedge clk);
        #1;
    endtask
    initial begin
        m.op_valid = 1'b0; m.md_op = 3'd0; m.a = '0; m.b = '0; m.d_md = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(m.busy), 32'd0);
        check("reset_stall", 32'(m.stall), 32'd0);
        reset_n = 1'b1;
        req(32'h0, 32'h0);
        // mult with stall observed from the start cycle until busy falls
        expect_op(32'hFFFFFFFF, 32'hFFFFFFFE, 5);
        @(posedge clk); #1;
        m.op_valid = 1'b1; m.md_op = 3'd0; m.a = 32'hFFFFFFFF; m.b = 32'h2; m.d_md = 1'b1;
        #1 check("stall_start", 32'(m.stall), 32'd1);
        @(posedge clk); #1;
        m.op_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 check("stall_run", 32'(m.stall), 32'd1);
            @(posedge clk); #1;
        end
        #1 check("stall_after", 32'(m.stall), 32'd0);
        m.d_md = 1'b0;
        wait_idle();
        // multu; stall must stay low with d_md=0
        expect_op(32'h00000001, 32'hFFFFFFFE, 5);
        @(posedge clk); #1;
        m.op_valid = 1'b1; m.md_op = 3'd1; m.a = 32'hFFFFFFFF; m.b = 32'h2;
        #1 check("stall_no_dmd", 32'(m.stall), 32'd0);
        @(posedge clk); #1;
        m.op_valid = 1'b0;
        wait_idle();
        expect_op(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        issue(3'd2, 32'hFFFFFFF9, 32'h2);
        wait_idle();
        expect_op(32'h1, 32'h3, 10);
        issue(3'd3, 32'h7, 32'h2);
        wait_idle();
        issue(3'd4, 32'h1234, 32'h0);
        check("mthi_busy", 32'(m.busy), 32'd0);
        req(32'h1234, 32'h3);
        issue(3'd5, 32'h5678, 32'h0);
        req(32'h1234, 32'h5678);
        expect_op(32'h1234, 32'h5678, 10);
        issue(3'd2, 32'd100, 32'h0);
        wait_idle();
        expect_op(32'h0, 32'h80000000, 10);
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_idle();
        expect_op(32'h0, 32'd15, 5);
        issue(3'd0, 32'hFFFFFFFD, 32'hFFFFFFFB);
        wait_idle();
        // op_valid during RUN and md_op 6 in IDLE are both ignored
        expect_op(32'h0, 32'd12, 5);
        issue(3'd0, 32'd3, 32'd4);
        @(posedge clk); #1;
        m.op_valid = 1'b1; m.md_op = 3'd4; m.a = 32'hDEAD;
        @(posedge clk); #1;
        m.op_valid = 1'b0;
        wait_idle();
        issue(3'd6, 32'hBEEF, 32'h1);
        check("op6_busy", 32'(m.busy), 32'd0);
        req(32'h0, 32'd12);
        // reset in RUN cycle 3
        expect_op(32'h0, 32'h0, 3);
        issue(3'd3, 32'd100, 32'd7);
        repeat (2) begin
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("reset_abort_busy", 32'(m.busy), 32'd0);
        reset_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        req(32'h0, 32'h0);
`ifdef MD_CANCEL_EN
        issue(3'd4, 32'hAAAA, 32'h0);
        req(32'hAAAA, 32'h0);
        expect_op(32'hAAAA, 32'h0, 2);
        issue(3'd0, 32'd2, 32'd3);
        @(posedge clk); #1;
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        check("cancel_busy", 32'(m.busy), 32'd0);
        repeat (12) @(posedge clk);
        #1;
        req(32'hAAAA, 32'h0);
        @(posedge clk); #1;
        m.op_valid = 1'b1; m.md_op = 3'd5; m.a = 32'h55; cancel = 1'b1;
        @(posedge clk); #1;
        m.op_valid = 1'b0; cancel = 1'b0;
        req(32'hAAAA, 32'h0);
        @(posedge clk); #1;
        m.op_valid = 1'b1; m.md_op = 3'd0; m.a = 32'd9; m.b = 32'd9; cancel = 1'b1;
        @(posedge clk); #1;
        m.op_valid = 1'b0; cancel = 1'b0;
        check("cancel_start_busy", 32'(m.busy), 32'd0);
        req(32'hAAAA, 32'h0);
`endif
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected entries never observed", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
